// File: rtl/up_mem_if.sv
// up_mem_if: turns the controller's ale/mem_we strobes into req/ack memory bus
// accesses with wait states, a timeout abort and one pending-request slot.
module up_mem_if #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          ale,
    input  logic [AW-1:0] addr_in,
    input  logic          mem_we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          mem_re,
    output logic          busy,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          err,
    output logic          ovf
);
    // state  | meaning
    // IDLE   | nothing in flight, pending slot empty
    // ACCESS | bus_req high, waiting for bus_ack or timeout
    // DONE   | access finished; mem_re pulses for a read
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic          pend_v;
    logic          pend_wr;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic          from_slot;

    logic acked;
    logic timed_out;
    logic finish;
    logic direct;
    logic any_req;

    assign acked     = (state == ACCESS) & bus_ack;
    assign timed_out = (state == ACCESS) & ~bus_ack & (cnt == CW'(TIMEOUT - 1));
    assign finish    = acked | timed_out;
    assign any_req   = ale | mem_we;
    // New requests may go straight onto the bus only when nothing is queued ahead.
    assign direct    = (state == IDLE) | ((state == DONE) & ~pend_v);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (finish) state_next = DONE;
            DONE:    state_next = (pend_v | any_req) ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state == ACCESS);
        mem_re  = (state == DONE) & ~bus_wr;
        busy    = (state != IDLE) | pend_v;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt       <= '0;
            addr_q    <= '0;
            pend_v    <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            from_slot <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (ale) addr_q <= addr_in;

            cnt <= (state == ACCESS) ? cnt + CW'(1) : '0;

            if (acked & ~bus_wr) begin
                rdata <= bus_rdata;
            end else if (timed_out & ~bus_wr) begin
                rdata <= '1;
            end
            if (timed_out) err <= 1'b1;

            // A promoted entry keeps the slot occupied until its access ends.
            if (finish & from_slot) begin
                pend_v    <= 1'b0;
                from_slot <= 1'b0;
            end

            if (direct) begin
                if (mem_we) begin
                    bus_wr    <= 1'b1;
                    bus_addr  <= addr_q;
                    bus_wdata <= wdata;
                    if (ale) begin
                        pend_v    <= 1'b1;
                        pend_wr   <= 1'b0;
                        pend_addr <= addr_in;
                    end
                end else if (ale) begin
                    bus_wr   <= 1'b0;
                    bus_addr <= addr_in;
                end
            end else begin
                if (state == DONE) begin
                    bus_wr    <= pend_wr;
                    bus_addr  <= pend_addr;
                    bus_wdata <= pend_data;
                    from_slot <= 1'b1;
                end
                if (pend_v) begin
                    if (any_req) ovf <= 1'b1;
                end else if (mem_we) begin
                    pend_v    <= 1'b1;
                    pend_wr   <= 1'b1;
                    pend_addr <= addr_q;
                    pend_data <= wdata;
                    if (ale) ovf <= 1'b1;
                end else if (ale) begin
                    pend_v    <= 1'b1;
                    pend_wr   <= 1'b0;
                    pend_addr <= addr_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_up_mem_if.sv
// tb_up_mem_if: directed checks of up_mem_if against a scripted memory bus responder.
module tb_up_mem_if;
    logic       clk;
    logic       nRst;
    logic       ale;
    logic [7:0] addr_in;
    logic       mem_we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       mem_re;
    logic       busy;
    logic       bus_req;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       err;
    logic       ovf;

    up_mem_if #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk(clk), .nRst(nRst), .ale(ale), .addr_in(addr_in), .mem_we(mem_we),
        .wdata(wdata), .rdata(rdata), .mem_re(mem_re), .busy(busy),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .err(err), .ovf(ovf)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         wait_cfg = 0;
    bit         no_ack = 0;
    bit         echo = 0;
    logic [7:0] rd_val = 8'h00;
    int         waited = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Bus responder: acks after wait_cfg wait states; echo returns addr^C0.
    initial begin
        bus_ack   = 0;
        bus_rdata = 0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                bus_ack   = !no_ack && (waited == wait_cfg);
                bus_rdata = echo ? (bus_addr ^ 8'hC0) : rd_val;
                waited++;
            end else begin
                bus_ack = 0;
                waited  = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        nRst    = 0;
        ale     = 0;
        mem_we  = 0;
        addr_in = 0;
        wdata   = 0;
        repeat (2) @(negedge clk);
        nRst = 1;
        @(negedge clk);
    endtask

    int         n_re;
    int         re_cyc;
    logic [7:0] re_dat;
    int         wr_cyc;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    int         last_busy;
    int         n_txn;
    logic       prev_req;
    int         n_req_cyc;
    logic [7:0] re_log [4];
    logic       tw [4];
    logic [7:0] ta [4];
    logic [7:0] td [4];

    initial begin
        do_reset();
        check("reset_outs", 32'({rdata, bus_addr, bus_wdata, mem_re, busy, bus_req, bus_wr, err, ovf}), 0);

        // 1: zero-wait read
        wait_cfg = 0; no_ack = 0; echo = 0; rd_val = 8'hA5;
        ale = 1; addr_in = 8'h3C;
        @(negedge clk);
        ale = 0; addr_in = 0;
        check("t1_req", 32'(bus_req), 1);
        check("t1_addr", 32'(bus_addr), 'h3C);
        check("t1_wr", 32'(bus_wr), 0);
        check("t1_re_early", 32'(mem_re), 0);
        @(negedge clk);
        check("t1_mem_re", 32'(mem_re), 1);
        check("t1_rdata", 32'(rdata), 'hA5);
        check("t1_req_low", 32'(bus_req), 0);
        @(negedge clk);
        check("t1_re_single", 32'(mem_re), 0);
        check("t1_rdata_hold", 32'(rdata), 'hA5);
        check("t1_busy", 32'(busy), 0);

        // 2: read then queued write, 3 wait states
        do_reset();
        wait_cfg = 3; rd_val = 8'h5A;
        n_re = 0; re_cyc = -1; re_dat = 0; wr_cyc = -1; wr_addr = 0; wr_data = 0; last_busy = -1;
        ale = 1; addr_in = 8'h10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            ale    = 0;
            mem_we = (i == 1);
            wdata  = 8'h77;
            if (mem_re) begin n_re++; re_cyc = i; re_dat = rdata; end
            if (bus_req && bus_wr && wr_cyc < 0) begin
                wr_cyc = i; wr_addr = bus_addr; wr_data = bus_wdata;
            end
            if (busy) last_busy = i;
        end
        check("t2_n_mem_re", n_re, 1);
        check("t2_re_cycle", re_cyc, 5);
        check("t2_rdata", 32'(re_dat), 'h5A);
        check("t2_wr_cycle", wr_cyc, 6);
        check("t2_wr_addr", 32'(wr_addr), 'h10);
        check("t2_wr_data", 32'(wr_data), 'h77);
        check("t2_last_busy", last_busy, 10);

        // 3: ale on four consecutive cycles
        do_reset();
        wait_cfg = 0; echo = 1;
        n_re = 0; n_txn = 0; prev_req = 0;
        for (int k = 0; k < 4; k++) re_log[k] = 0;
        for (int i = 0; i < 16; i++) begin
            ale = (i < 4); addr_in = 8'(i);
            @(negedge clk);
            if (mem_re) begin
                if (n_re < 4) re_log[n_re] = rdata;
                n_re++;
            end
            if (bus_req && !prev_req) n_txn++;
            prev_req = bus_req;
        end
        ale = 0;
        check("t3_n_txn", n_txn, 2);
        check("t3_n_mem_re", n_re, 2);
        check("t3_rd0", 32'(re_log[0]), 'hC0);
        check("t3_rd1", 32'(re_log[1]), 'hC1);
        check("t3_ovf", 32'(ovf), 1);
        check("t3_err", 32'(err), 0);
        mem_we = 1; wdata = 8'h9E;
        @(negedge clk);
        mem_we = 0;
        check("t3_wr_req", 32'({bus_req, bus_wr}), 'h3);
        check("t3_addr_q", 32'(bus_addr), 'h03);
        check("t3_wr_data", 32'(bus_wdata), 'h9E);
        repeat (3) @(negedge clk);

        // 4: timeout
        do_reset();
        no_ack = 1; echo = 0; rd_val = 8'h00;
        n_re = 0; n_req_cyc = 0; re_dat = 0;
        ale = 1; addr_in = 8'h20;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            ale = 0;
            if (bus_req) n_req_cyc++;
            if (mem_re) begin n_re++; re_dat = rdata; end
        end
        no_ack = 0;
        check("t4_req_cycles", n_req_cyc, 15);
        check("t4_n_mem_re", n_re, 1);
        check("t4_rdata", 32'(re_dat), 'hFF);
        check("t4_err", 32'(err), 1);
        check("t4_ovf", 32'(ovf), 0);

        // 5: ale and mem_we in the same cycle
        do_reset();
        wait_cfg = 0; echo = 1;
        ale = 1; addr_in = 8'h05;
        @(negedge clk);
        ale = 0;
        repeat (3) @(negedge clk);
        n_txn = 0; n_re = 0; prev_req = 0; re_dat = 0;
        for (int k = 0; k < 4; k++) begin tw[k] = 0; ta[k] = 0; td[k] = 0; end
        ale = 1; addr_in = 8'h06; mem_we = 1; wdata = 8'h11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ale = 0; mem_we = 0;
            if (bus_req && !prev_req) begin
                if (n_txn < 4) begin tw[n_txn] = bus_wr; ta[n_txn] = bus_addr; td[n_txn] = bus_wdata; end
                n_txn++;
            end
            prev_req = bus_req;
            if (mem_re) begin n_re++; re_dat = rdata; end
        end
        check("t5_n_txn", n_txn, 2);
        check("t5_first", 32'({tw[0], ta[0], td[0]}), 'h10511);
        check("t5_second", 32'({tw[1], ta[1]}), 'h006);
        check("t5_n_mem_re", n_re, 1);
        check("t5_rdata", 32'(re_dat), 'hC6);
        check("t5_ovf", 32'(ovf), 0);

        // 6: reset mid-transaction
        no_ack = 1;
        ale = 1; addr_in = 8'h44;
        @(negedge clk);
        ale = 0;
        @(negedge clk);
        check("t6_req_before", 32'(bus_req), 1);
        #2 nRst = 0;
        #1;
        check("t6_req_dropped", 32'(bus_req), 0);
        check("t6_outs_zero", 32'({rdata, bus_addr, bus_wdata, mem_re, busy, bus_req, bus_wr, err, ovf}), 0);
        @(negedge clk);
        @(negedge clk);
        nRst = 1; no_ack = 0;
        n_re = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_re) n_re++;
        end
        check("t6_no_mem_re", n_re, 0);
        check("t6_idle", 32'({busy, bus_req}), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
